sha256_block_sched: RTL
=======================

# sha256_block_sched

Sequencer that owns the SHA-256 core's input handshake. It buffers one 512-bit pre-padded message block (16 × 32-bit words) from a producer, then pulses the core's start input and streams the 16 words, one per cycle with data-valid. It waits for the core's done, with a timeout, and holds the captured 256-bit digest for the consumer. It sits between the bus-side register wrapper (or a DMA) and the SHA-256 core instance, so software never has to time the core's word-by-word protocol itself.

## Interface
- TIMEOUT_CYCLES, 1024, max cycles in WAIT before abort; ≥ 80 required
- CNT_W, 11, width of timeout counter; must hold TIMEOUT_CYCLES
- iClk  in  1  clock, all logic rising-edge
- iReset_n  in  1  asynchronous, active-low reset
- iWord  in  32  producer word, big-endian word order (word 0 first)
- iWordValid  in  1  producer word valid
- oWordReady  out  1  buffer accepts word this cycle
- iGo  in  1  launch hash of buffered block
- iClear  in  1  abort/acknowledge; returns block to IDLE
- oCoreStart  out  1  one-cycle start pulse to core
- oCoreDataValid  out  1  core data-valid
- oCoreDataIn  out  32  core data word
- iCoreDone  in  1  core done (level or pulse; first high cycle used)
- iCoreDigest  in  256  core digest, valid while iCoreDone high
- oDigest  out  256  captured digest
- oDigestValid  out  1  oDigest valid
- oBusy  out  1  high in START, STREAM, WAIT
- oTimeout  out  1  sticky: last job aborted by timeout

## Operation
- States: LOAD, START, STREAM, WAIT, DONE.
- LOAD:
  - oWordReady = (count < 16).
  - A word is accepted on a cycle with iWordValid && oWordReady: written to buf[count], count++.
  - iGo with count == 16 → START. iGo with count < 16 is ignored (no error).
- START: oCoreStart = 1 for exactly one cycle; clear timeout counter → STREAM, idx = 0.
- STREAM: oCoreDataValid = 1, oCoreDataIn = buf[idx], idx++ each cycle. After idx 15 → WAIT.
- iCoreDone outside WAIT is ignored.
- WAIT:
  - Counter increments each cycle.
  - iCoreDone → capture iCoreDigest into oDigest, go to DONE.
  - Counter == TIMEOUT_CYCLES−1 without done → set oTimeout, count = 0, go to LOAD.
- DONE: oDigestValid = 1. iClear or iGo → count = 0, oDigestValid = 0, go to LOAD. The iGo does not launch a new job in the same cycle.
- iClear in any state:
  - Next state LOAD, count = 0.
  - oTimeout cleared, oDigestValid cleared.
  - In START/STREAM/WAIT it aborts; the core is not notified. Software must re-hash.
- iClear has priority over every other event, including a simultaneous iCoreDone or iGo.
- oDigest keeps its last value until the next capture; it is only cleared by reset.
- In LOAD, oCoreDataValid = oCoreStart = 0 and oCoreDataIn = 0.

## Timing
- Reset values:
  - State LOAD, count 0, idx 0.
  - oWordReady 1.
  - oCoreStart, oCoreDataValid, oBusy, oTimeout, oDigestValid 0.
  - oCoreDataIn 0, oDigest 0.
- All outputs are registered or decoded from registered state only. There is no combinational path from input to output.
- iGo sampled at edge N → oCoreStart high in cycle N+1.
- Word 0 with oCoreDataValid is in cycle N+2; word 15 is in N+17.
- iCoreDone sampled at edge M → oDigestValid and the new oDigest are visible from cycle M+1.
- Fill: one word per cycle maximum; 16 words take ≥ 16 cycles.
- Reset mid-operation: immediate return to reset values. The buffer contents are don't-care.

## Structure
- Shared package sha256_pkg holds:
  - state enum
  - BLOCK_WORDS = 16
  - WORD_W = 32
  - DIGEST_W = 256
  - idx/count widths
- Sub-module sha256_word_buf:
  - 16×32 register file with write port (addr, data, we) and asynchronous read port.
  - Reset not required on the array.
- FSM, counters and digest capture stay in the top.

## Test plan
- Basic hash:
  - Stimulus: load the padded "abc" block (word 0 = 0x61626380, words 1–14 = 0, word 15 = 0x00000018), pulse iGo. The core model returns done after 64 cycles with the "abc" digest.
  - Required: oCoreStart 1 cycle later, words streamed in order in cycles N+2..N+17, oDigest = ba7816bf…f20015ad with oDigestValid high.
- Backpressure: present 20 consecutive valid words in LOAD → oWordReady drops after 16; words 17–20 are not accepted; buffer holds words 1–16.
- Early iGo: iGo after 10 words → stays in LOAD, oCoreStart stays 0. After 6 more words plus iGo → normal job.
- Timeout: TIMEOUT_CYCLES = 100, core never asserts done → oTimeout = 1 exactly 100 cycles after word 15, oBusy = 0, count = 0. A subsequent iClear clears oTimeout.
- Abort and collisions:
  - iClear during STREAM at word 7 → oCoreDataValid 0 next cycle, state LOAD, oDigest unchanged.
  - iClear coincident with iCoreDone in WAIT → no capture, oDigestValid 0.
- Reset mid-WAIT: assert iReset_n low asynchronously → all outputs at reset values before the next clock edge. After release, a new block hashes correctly.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared types and sizes for the SHA-256 block sequencer and its word buffer.
package sha256_pkg;

    localparam int BLOCK_WORDS = 16;
    localparam int WORD_W      = 32;
    localparam int DIGEST_W    = 256;
    localparam int IDX_W       = 4;   // addresses words 0..15
    localparam int COUNT_W     = 5;   // holds fill levels 0..16

    // Fill level at which the buffer holds a complete block
    localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(BLOCK_WORDS);
    // Index of the final word streamed to the core
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(BLOCK_WORDS - 1);

    typedef enum logic [2:0] {
        ST_LOAD   = 3'd0,
        ST_START  = 3'd1,
        ST_STREAM = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/sha256_word_buf.sv
// 16 x 32-bit register file holding one message block.
// Single write port, asynchronous read port; contents are not reset.
module sha256_word_buf
    import sha256_pkg::*;
(
    input  logic              iClk,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [IDX_W-1:0]  i_raddr,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [BLOCK_WORDS];

    generate
        for (genvar gi = 0; gi < BLOCK_WORDS; gi++) begin : g_word
            // Each word register loads when the write address selects it
            always_ff @(posedge iClk) begin
                if (i_we && (i_waddr == IDX_W'(gi))) begin
                    r_mem[gi] <= i_wdata;
                end
            end
        end
    endgenerate

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sha256_block_sched.sv
// Sequencer between a word producer and a SHA-256 core: buffers one
// pre-padded 512-bit block, launches the core, streams the 16 words,
// waits (bounded) for done and holds the captured digest.
// Every output is a register or a decode of registered state.
module sha256_block_sched
    import sha256_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic                iClk,
    input  logic                iReset_n,
    input  logic [WORD_W-1:0]   iWord,
    input  logic                iWordValid,
    output logic                oWordReady,
    input  logic                iGo,
    input  logic                iClear,
    output logic                oCoreStart,
    output logic                oCoreDataValid,
    output logic [WORD_W-1:0]   oCoreDataIn,
    input  logic                iCoreDone,
    input  logic [DIGEST_W-1:0] iCoreDigest,
    output logic [DIGEST_W-1:0] oDigest,
    output logic                oDigestValid,
    output logic                oBusy,
    output logic                oTimeout
);

    // Last WAIT counter value before the job is abandoned
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [COUNT_W-1:0]    r_count;
    logic [IDX_W-1:0]      r_idx;
    logic [CNT_W-1:0]      r_tmo_cnt;
    logic [DIGEST_W-1:0]   r_digest;
    logic                  r_timeout;

    logic                  w_full;
    logic                  w_tmo_hit;
    logic                  w_accept;
    logic [WORD_W-1:0]     w_rdata;

    assign w_full    = (r_count == FULL_COUNT);
    assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);
    // A clear in the same cycle wins over an incoming word
    assign w_accept  = (r_state == ST_LOAD) && iWordValid && !w_full && !iClear;

    sha256_word_buf u_word_buf (
        .iClk    (iClk),
        .i_we    (w_accept),
        .i_waddr (r_count[IDX_W-1:0]),
        .i_wdata (iWord),
        .i_raddr (r_idx),
        .o_rdata (w_rdata)
    );

    // State register
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; iClear overrides every other event
    always_comb begin
        w_state_next = r_state;
        if (iClear) begin
            w_state_next = ST_LOAD;
        end else begin
            case (r_state)
                ST_LOAD:   if (iGo && w_full)         w_state_next = ST_START;
                ST_START:                             w_state_next = ST_STREAM;
                ST_STREAM: if (r_idx == LAST_IDX)     w_state_next = ST_WAIT;
                ST_WAIT: begin
                    if (iCoreDone)                    w_state_next = ST_DONE;
                    else if (w_tmo_hit)               w_state_next = ST_LOAD;
                end
                ST_DONE:   if (iGo)                   w_state_next = ST_LOAD;
                default:                              w_state_next = ST_LOAD;
            endcase
        end
    end

    // Output decode from registered state only
    always_comb begin
        oWordReady     = 1'b0;
        oCoreStart     = 1'b0;
        oCoreDataValid = 1'b0;
        oCoreDataIn    = '0;
        oBusy          = 1'b0;
        oDigestValid   = 1'b0;
        case (r_state)
            ST_LOAD:   oWordReady = !w_full;
            ST_START: begin
                oCoreStart = 1'b1;
                oBusy      = 1'b1;
            end
            ST_STREAM: begin
                oCoreDataValid = 1'b1;
                oCoreDataIn    = w_rdata;
                oBusy          = 1'b1;
            end
            ST_WAIT:   oBusy        = 1'b1;
            ST_DONE:   oDigestValid = 1'b1;
            default:   oWordReady   = 1'b0;
        endcase
    end

    assign oDigest  = r_digest;
    assign oTimeout = r_timeout;

    // Fill level: grows on accepted words, returns to zero whenever the job ends
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_count <= '0;
        end else if (iClear) begin
            r_count <= '0;
        end else begin
            case (r_state)
                ST_LOAD: if (w_accept)                 r_count <= r_count + 1'b1;
                ST_WAIT: if (!iCoreDone && w_tmo_hit)  r_count <= '0;
                ST_DONE: if (iGo)                      r_count <= '0;
                default:                               r_count <= r_count;
            endcase
        end
    end

    // Stream read index and WAIT timeout counter, both armed in START
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_idx     <= '0;
            r_tmo_cnt <= '0;
        end else begin
            case (r_state)
                ST_START: begin
                    r_idx     <= '0;
                    r_tmo_cnt <= '0;
                end
                ST_STREAM: r_idx     <= r_idx + 1'b1;
                ST_WAIT:   r_tmo_cnt <= r_tmo_cnt + 1'b1;
                default: begin
                    r_idx     <= r_idx;
                    r_tmo_cnt <= r_tmo_cnt;
                end
            endcase
        end
    end

    // Digest capture on the first done seen in WAIT; sticky timeout flag
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_digest  <= '0;
            r_timeout <= 1'b0;
        end else if (iClear) begin
            r_timeout <= 1'b0;
        end else if (r_state == ST_WAIT) begin
            if (iCoreDone) begin
                r_digest <= iCoreDigest;
            end else if (w_tmo_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

endmodule
